// File: rtl/flash_program_sequencer.sv
// ---------------------------------------------------------------------------
// flash_program_sequencer
//
// Purpose: runs one flash operation through the command/status registers of a
// serial-flash controller. The operation is sector erase, block erase, page
// program or chip erase. The sequence for each operation is:
//   1. Write-enable command, then wait for the controller to go idle.
//   2. Target address (not sent for chip erase).
//   3. Page data bytes (program only).
//   4. The operation command, then wait for the controller to go idle.
//   5. Poll the flash status register until BUSY clears or the poll budget
//      runs out.
// Program requests that are empty, larger than 256 bytes or that cross a
// 256-byte page are refused without touching the bus.
//
// Optional feature: define FLASH_SEQ_WEL_CHECK_EN to read the status register
// after write-enable. With this macro, a clear WEL bit ends the operation with
// an error.
//
// Ports:
//   i_Clk, i_nReset          clock (rising edge), async active-low reset
//   i_Start, i_Op            request strobe and operation
//                            (0 sector, 1 block, 2 program, 3 chip)
//   i_FlashAddr, i_ByteCount target byte address, program length 1..256
//   o_DataReq, i_DataValid,
//   i_Data                   program byte handshake
//   o_Busy, o_Done, o_Error  status; o_Error qualifies the o_Done pulse
//   o_AV_*, i_AV_*           Avalon-MM master to the controller
//                            (regs 0 CNTRL, 1 ADDR, 2 DATA)
// ---------------------------------------------------------------------------
module flash_program_sequencer #(
  parameter int POLL_LIMIT = 4096,
  parameter int ADDR_W     = 24
) (
  input  logic              i_Clk,
  input  logic              i_nReset,
  input  logic              i_Start,
  input  logic [1:0]        i_Op,
  input  logic [ADDR_W-1:0] i_FlashAddr,
  input  logic [8:0]        i_ByteCount,
  output logic              o_DataReq,
  input  logic              i_DataValid,
  input  logic [7:0]        i_Data,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error,
  output logic [1:0]        o_AV_RegAddr,
  output logic              o_AV_Read,
  output logic              o_AV_Write,
  output logic [3:0]        o_AV_ByteEn,
  output logic [31:0]       o_AV_WriteData,
  input  logic [31:0]       i_AV_ReadData,
  input  logic              i_AV_WaitRequest
);

  typedef enum logic [3:0] {
    IDLE, CHECK, WREN, WAIT_CTL, SET_ADDR, PUSH_DATA, ISSUE_OP,
    POLL_CMD, POLL_READ, DONE, WEL_CMD, WEL_READ
  } stateT;

  localparam logic [1:0]  REG_CNTRL = 2'd0;
  localparam logic [1:0]  REG_ADDR  = 2'd1;
  localparam logic [1:0]  REG_DATA  = 2'd2;

  localparam logic [3:0]  CMD_WREN    = 4'd0;
  localparam logic [3:0]  CMD_SECTOR  = 4'd1;
  localparam logic [3:0]  CMD_BLOCK   = 4'd2;
  localparam logic [3:0]  CMD_CHIP    = 4'd3;
  localparam logic [3:0]  CMD_PROGRAM = 4'd4;
  localparam logic [3:0]  CMD_READ_SR = 4'd6;

  localparam logic [1:0]  OP_PROGRAM = 2'd2;
  localparam logic [1:0]  OP_CHIP    = 2'd3;

  localparam logic [15:0] POLL_LIMIT_W = 16'(POLL_LIMIT);

  // Command word: opcode in [3:0], start bit 8.
  function automatic logic [31:0] cmdWord(input logic [3:0] cmd);
    return {23'd0, 1'b1, 4'd0, cmd};
  endfunction

  stateT             state, stateNext;
  stateT             retState, retNext;   // where WAIT_CTL goes once the controller is idle
  stateT             afterWren, afterWel;
  logic [1:0]        opLatch;
  logic [ADDR_W-1:0] addrLatch;
  logic [8:0]        countLatch;
  logic [8:0]        bytesLeft;
  logic [7:0]        dataByte;
  logic              dataPending;          // a byte is held and its DATA write is outstanding
  logic [15:0]       pollCount;
  logic [15:0]       pollNext;
  logic              errFlag;
  logic              errSet;
  logic              xferDone;
  logic              pageBad;
  logic [9:0]        pageEnd;
  logic [3:0]        opCmd;

  logic              avRead, avWrite, dataReq, doneOut;
  logic [1:0]        avRegAddr;
  logic [3:0]        avByteEn;
  logic [31:0]       avWriteData;

  assign xferDone = (avRead | avWrite) & ~i_AV_WaitRequest;
  assign pollNext = pollCount + 16'd1;

  // The end of the page window uses 10 bits so a 255 + 256 overflow cannot wrap.
  assign pageEnd = {2'b00, addrLatch[7:0]} + {1'b0, countLatch};
  assign pageBad = (countLatch == 9'd0) || (countLatch > 9'd256) || (pageEnd > 10'd256);

  always_comb begin
    case (opLatch)
      2'd0:    opCmd = CMD_SECTOR;
      2'd1:    opCmd = CMD_BLOCK;
      2'd2:    opCmd = CMD_PROGRAM;
      default: opCmd = CMD_CHIP;
    endcase
  end

  // Chip erase has no address phase.
  assign afterWel = (opLatch == OP_CHIP) ? ISSUE_OP : SET_ADDR;
`ifdef FLASH_SEQ_WEL_CHECK_EN
  assign afterWren = WEL_CMD;
`else
  assign afterWren = afterWel;
`endif

  always_comb begin
    stateNext   = state;
    retNext     = retState;
    errSet      = 1'b0;
    avRead      = 1'b0;
    avWrite     = 1'b0;
    avRegAddr   = REG_CNTRL;
    avByteEn    = 4'b0000;
    avWriteData = 32'd0;
    dataReq     = 1'b0;
    doneOut     = 1'b0;

    case (state)
      IDLE: begin
        if (i_Start) stateNext = CHECK;
      end

      CHECK: begin
        if ((opLatch == OP_PROGRAM) && pageBad) begin
          errSet    = 1'b1;
          stateNext = DONE;
        end else begin
          stateNext = WREN;
        end
      end

      WREN: begin
        avWrite     = 1'b1;
        avByteEn    = 4'b1111;
        avWriteData = cmdWord(CMD_WREN);
        if (xferDone) begin
          stateNext = WAIT_CTL;
          retNext   = afterWren;
        end
      end

      WAIT_CTL: begin
        avRead = 1'b1;
        // Bit 9 of CNTRL is the controller's own busy flag.
        if (xferDone && !i_AV_ReadData[9]) stateNext = retState;
      end

      SET_ADDR: begin
        avWrite     = 1'b1;
        avRegAddr   = REG_ADDR;
        avByteEn    = 4'b1111;
        avWriteData = 32'(addrLatch);
        if (xferDone) stateNext = (opLatch == OP_PROGRAM) ? PUSH_DATA : ISSUE_OP;
      end

      PUSH_DATA: begin
        dataReq = ~dataPending;
        if (dataPending) begin
          avWrite     = 1'b1;
          avRegAddr   = REG_DATA;
          avByteEn    = 4'b0001;
          avWriteData = {24'd0, dataByte};
          if (xferDone && (bytesLeft == 9'd1)) stateNext = ISSUE_OP;
        end
      end

      ISSUE_OP: begin
        avWrite     = 1'b1;
        avByteEn    = 4'b1111;
        avWriteData = cmdWord(opCmd);
        if (xferDone) begin
          stateNext = WAIT_CTL;
          retNext   = POLL_CMD;
        end
      end

      POLL_CMD: begin
        avWrite     = 1'b1;
        avByteEn    = 4'b1111;
        avWriteData = cmdWord(CMD_READ_SR);
        if (xferDone) begin
          stateNext = WAIT_CTL;
          retNext   = POLL_READ;
        end
      end

      POLL_READ: begin
        avRead    = 1'b1;
        avRegAddr = REG_DATA;
        if (xferDone) begin
          if (!i_AV_ReadData[0]) begin
            stateNext = DONE;
          end else if (pollNext >= POLL_LIMIT_W) begin
            errSet    = 1'b1;
            stateNext = DONE;
          end else begin
            stateNext = POLL_CMD;
          end
        end
      end

`ifdef FLASH_SEQ_WEL_CHECK_EN
      WEL_CMD: begin
        avWrite     = 1'b1;
        avByteEn    = 4'b1111;
        avWriteData = cmdWord(CMD_READ_SR);
        if (xferDone) begin
          stateNext = WAIT_CTL;
          retNext   = WEL_READ;
        end
      end

      WEL_READ: begin
        avRead    = 1'b1;
        avRegAddr = REG_DATA;
        if (xferDone) begin
          if (!i_AV_ReadData[1]) begin
            errSet    = 1'b1;
            stateNext = DONE;
          end else begin
            stateNext = afterWel;
          end
        end
      end
`endif

      DONE: begin
        doneOut   = 1'b1;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state       <= IDLE;
      retState    <= IDLE;
      opLatch     <= 2'd0;
      addrLatch   <= '0;
      countLatch  <= 9'd0;
      bytesLeft   <= 9'd0;
      dataByte    <= 8'd0;
      dataPending <= 1'b0;
      pollCount   <= 16'd0;
      errFlag     <= 1'b0;
    end else begin
      state    <= stateNext;
      retState <= retNext;

      if ((state == IDLE) && i_Start) begin
        opLatch     <= i_Op;
        addrLatch   <= i_FlashAddr;
        countLatch  <= i_ByteCount;
        bytesLeft   <= i_ByteCount;
        dataPending <= 1'b0;
        errFlag     <= 1'b0;
      end

      if (state == CHECK) pollCount <= 16'd0;
      if (errSet) errFlag <= 1'b1;

      if (state == PUSH_DATA) begin
        if (dataPending) begin
          if (xferDone) begin
            dataPending <= 1'b0;
            bytesLeft   <= bytesLeft - 9'd1;
          end
        end else if (i_DataValid) begin
          dataByte    <= i_Data;
          dataPending <= 1'b1;
        end
      end

      if ((state == POLL_READ) && xferDone) pollCount <= pollNext;
    end
  end

  // All outputs are decoded from registered state, so an asynchronous reset
  // (which forces IDLE) drives every one of them low at once.
  assign o_Busy         = (state != IDLE);
  assign o_Done         = doneOut;
  assign o_Error        = doneOut & errFlag;
  assign o_DataReq      = dataReq;
  assign o_AV_Read      = avRead;
  assign o_AV_Write     = avWrite;
  assign o_AV_RegAddr   = avRegAddr;
  assign o_AV_ByteEn    = avByteEn;
  assign o_AV_WriteData = avWriteData;

  // Only status bits 0, 1 and 9 carry meaning here.
  logic unusedReadBits;
  assign unusedReadBits = ^{i_AV_ReadData[31:10], i_AV_ReadData[8:1]};

endmodule

// File: doc/flash_program_sequencer.md
FLASH_PROGRAM_SEQUENCER -- requirements
Module: flash_program_sequencer

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 4096: maximum status-register reads per operation before timeout.
REQ-002 SHALL have parameter ADDR_W, default 24: flash byte-address width.
REQ-003 SHALL have ports:
  - i_Clk  in  1  sole clock; rising edge.
  - i_nReset  in  1  reset, asynchronous, active-low.
  - i_Start  in  1  single-cycle request strobe.
  - i_Op  in  2  operation: 0 = sector erase 4KB, 1 = block erase 64KB, 2 = program page, 3 = chip erase.
  - i_FlashAddr  in  ADDR_W  target byte address.
  - i_ByteCount  in  9  program length, 1..256.
  - o_DataReq  out  1  program byte wanted.
  - i_DataValid  in  1  i_Data valid.
  - i_Data  in  8  program byte.
  - o_Busy  out  1  operation in progress.
  - o_Done  out  1  one-cycle completion pulse.
  - o_Error  out  1  qualifies o_Done: failed.
  - o_AV_RegAddr  out  2  controller register: 0 = CNTRL, 1 = ADDR, 2 = DATA.
  - o_AV_Read  out  1  Avalon read.
  - o_AV_Write  out  1  Avalon write.
  - o_AV_ByteEn  out  4  byte enables.
  - o_AV_WriteData  out  32  write data.
  - i_AV_ReadData  in  32  read data.
  - i_AV_WaitRequest  in  1  slave stall.

Function
REQ-004 SHALL master the flash controller CNTRL slave. A transfer completes on the edge where o_AV_Read or o_AV_Write is high and i_AV_WaitRequest is low. All master outputs SHALL hold stable while stalled. Read data is sampled in the completing cycle.
REQ-005 SHALL write commands to CNTRL with ByteEn 1111, command in data [3:0] and start in bit 8. Codes: WRITE_ENABLE = 0, SECTOR_ERASE_4KB = 1, BLOCK_ERASE_64KB = 2, CHIP_ERASE = 3, PROGRAM_PAGE = 4, READ_SR = 6.
REQ-006 After every command write, SHALL read CNTRL repeatedly until bit 9 (controller busy) reads 0 (state WAIT_CTL).
REQ-007 SHALL accept i_Start only in IDLE. i_Start while o_Busy is high SHALL be ignored. Operands SHALL be latched on acceptance, and o_Busy SHALL rise the next cycle.
REQ-008 In CHECK, program requests SHALL be rejected when i_ByteCount is 0, i_ByteCount exceeds 256, or i_FlashAddr[7:0] + i_ByteCount exceeds 256 (page crossing). Rejection SHALL issue no bus transfer and SHALL pulse o_Done together with o_Error 2 cycles after i_Start.
REQ-009 State order SHALL be: IDLE, CHECK, WREN, WAIT_CTL, SET_ADDR, (program only) PUSH_DATA, ISSUE_OP, WAIT_CTL, POLL_CMD, WAIT_CTL, POLL_READ, DONE, IDLE.
REQ-010 SET_ADDR SHALL write the latched address, zero-extended to 32 bits, to ADDR with ByteEn 1111. Chip erase SHALL skip SET_ADDR.
REQ-011 In PUSH_DATA, o_DataReq SHALL be high when no DATA write is pending. Each i_DataValid byte SHALL be written to DATA with ByteEn 0001. Exactly i_ByteCount writes SHALL be made, and o_DataReq SHALL drop in the cycle the last byte is accepted.
REQ-012 POLL_READ SHALL read DATA. If bit 0 (BUSY) = 1, the block SHALL return to POLL_CMD. If bit 0 = 0, it SHALL go to DONE.
REQ-013 The poll counter SHALL be 16 bits, cleared at CHECK and incremented per POLL_READ. On reaching POLL_LIMIT with BUSY still 1, the block SHALL go to DONE with o_Error = 1.
REQ-014 DONE SHALL last one cycle: o_Done = 1, o_Busy = 0 on the following cycle. Back-to-back i_Start on the cycle after DONE SHALL be accepted.
REQ-015 o_AV_Read and o_AV_Write SHALL never be high simultaneously.

Reset
REQ-016 On i_nReset low, SHALL immediately force IDLE and drive all outputs low, including o_AV_WriteData = 0 and o_AV_RegAddr = 0. A transfer in progress is abandoned.
REQ-017 Reset SHALL also clear the poll counter, byte counter and latched operands. Release SHALL take effect on the first i_Clk edge after deassertion.

Configuration
REQ-018 With macro FLASH_SEQ_WEL_CHECK_EN defined, each WREN SHALL be followed by READ_SR, WAIT_CTL and a DATA read. If bit 1 (WEL) = 0, the block SHALL go to DONE with o_Error = 1. Without the macro, WREN SHALL proceed directly to SET_ADDR.

Verification
REQ-019 Sector erase, Op = 0, Addr = 0x001000, SR reads 0x01 twice then 0x00 -> transfers CNTRL 0x100, ADDR 0x1000, CNTRL 0x101, then 3 READ_SR/DATA poll pairs; o_Done = 1, o_Error = 0.
REQ-020 Program, Op = 2, Addr = 0x0000F0, Count = 16, bytes 0x00..0x0F -> 16 DATA writes with ByteEn 0001 in order; CNTRL 0x104 after the last byte; o_Done with no error.
REQ-021 Program, Addr = 0x0000F8, Count = 16 (page crossing) -> no Avalon activity; o_Done and o_Error 2 cycles after i_Start.
REQ-022 i_AV_WaitRequest held high for 5 cycles on the ADDR write -> address and data held constant; exactly one ADDR transfer completes.
REQ-023 SR BUSY stuck at 1 with POLL_LIMIT = 8 -> exactly 8 DATA reads, then o_Done with o_Error = 1.
REQ-024 i_nReset pulsed low during PUSH_DATA after 3 bytes -> all outputs 0 asynchronously; a new i_Start after release runs a full sequence.
